// File: rtl/adder_stream_arbiter_if.sv
// Bundle of the requester, engine-input, engine-result and tagged-result
// handshakes around adder_stream_arbiter. The master view is the environment
// (requesters, engine, result consumer); the slave view is the arbiter itself.
interface adder_stream_arbiter_if #(
  parameter int K     = 4,
  parameter int WIDTH = 8,
  parameter int RES_W = 14,
  parameter int IDW   = $clog2(K)
);
  logic [K-1:0]            s_valid;
  logic [K-1:0]            s_ready;
  logic [K-1:0][WIDTH-1:0] s_data;
  logic                    m_valid;
  logic                    m_ready;
  logic [WIDTH-1:0]        m_data;
  logic                    r_valid;
  logic                    r_ready;
  logic [RES_W-1:0]        r_data;
  logic                    o_valid;
  logic                    o_ready;
  logic [RES_W-1:0]        o_data;
  logic [IDW-1:0]          o_id;

  modport master (
    output s_valid, s_data, m_ready, r_valid, r_data, o_ready,
    input  s_ready, m_valid, m_data, r_ready, o_valid, o_data, o_id
  );

  modport slave (
    input  s_valid, s_data, m_ready, r_valid, r_data, o_ready,
    output s_ready, m_valid, m_data, r_ready, o_valid, o_data, o_id
  );
endinterface

// File: rtl/adder_stream_arbiter.sv
// Round-robin arbiter sharing one N-beat summing engine among K requesters.
// A requester owns the engine for a whole group; the owner of every finished
// group is queued in a small ID FIFO and attached to the matching result.
module adder_stream_arbiter #(
  parameter int K        = 4,
  parameter int N        = 8,
  parameter int WIDTH    = 8,
  parameter int RES_W    = 14,
  parameter int ID_DEPTH = 4,
  parameter int IDW      = $clog2(K)
) (
  input  logic                clk,
  input  logic                rst,
  adder_stream_arbiter_if.slave bus,
  output logic                busy,
  output logic                err
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = (ID_DEPTH > 1) ? $clog2(ID_DEPTH) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]     state_reg, state_next;
  logic [IDW-1:0] grant_reg, grant_next;
  logic [IDW-1:0] rr_ptr_reg, rr_ptr_next;
  logic [CW-1:0]  beat_reg, beat_next;
  logic [IDW-1:0] pick;

  logic [IDW-1:0] id_mem [ID_DEPTH];
  logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]    count_reg;
  logic           err_reg;

  logic           live, in_burst, any_valid, m_fire, last_beat;
  logic           fifo_empty, fifo_full, push, pop;
  logic [K-1:0]   cand_valid;
  logic [IDW-1:0] cand_idx [K];

  // Outputs are forced quiet while reset is held, not just after it lands.
  assign live       = !rst;
  assign in_burst   = live && (state_reg == BURST);
  assign any_valid  = |bus.s_valid;
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == (PW+1)'(ID_DEPTH));

  // Candidate list rotated so that slot 0 is the current round-robin head.
  for (genvar gi = 0; gi < K; gi++) begin : g_rot
    assign cand_idx[gi]   = IDW'((32'(rr_ptr_reg) + 32'(gi)) % K);
    assign cand_valid[gi] = bus.s_valid[cand_idx[gi]];
  end

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    pick = rr_ptr_reg;
    for (int i = K - 1; i >= 0; i--) begin
      if (cand_valid[i]) pick = cand_idx[i];
    end
  end

  // Engine-facing side: only the locked grant is routed, and only in BURST.
  assign bus.m_valid = in_burst && bus.s_valid[grant_reg];
  assign bus.m_data  = in_burst ? bus.s_data[grant_reg] : '0;
  assign m_fire      = in_burst && bus.s_valid[grant_reg] && bus.m_ready;
  assign last_beat   = m_fire && (beat_reg == CW'(N - 1));

  for (genvar gi = 0; gi < K; gi++) begin : g_ready
    assign bus.s_ready[gi] = in_burst && bus.m_ready && (grant_reg == IDW'(gi));
  end

  // Result side: a result is only passed on when its owner is known.
  assign bus.o_valid = live && bus.r_valid && !fifo_empty;
  assign bus.r_ready = live && bus.o_ready && !fifo_empty;
  assign bus.o_data  = bus.r_data;
  assign bus.o_id    = id_mem[rd_ptr_reg];

  assign push = last_beat;
  assign pop  = live && bus.r_valid && bus.o_ready && !fifo_empty;

  assign busy = in_burst;
  assign err  = err_reg;

  // Grant / burst sequencing; a grant needs a free ID slot so the final push
  // of the burst can never overflow.
  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    rr_ptr_next = rr_ptr_reg;
    beat_next   = beat_reg;
    case (state_reg)
      IDLE: begin
        if (any_valid && !fifo_full) begin
          state_next = BURST;
          grant_next = pick;
          beat_next  = '0;
        end
      end
      BURST: begin
        if (m_fire) begin
          if (beat_reg == CW'(N - 1)) begin
            state_next  = IDLE;
            beat_next   = '0;
            rr_ptr_next = (grant_reg == IDW'(K - 1)) ? '0 : grant_reg + IDW'(1);
          end else begin
            beat_next = beat_reg + CW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM registers; reset drops any partially transferred group.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      rr_ptr_reg <= '0;
      beat_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      rr_ptr_reg <= rr_ptr_next;
      beat_reg   <= beat_next;
    end
  end

  // ID storage; contents need no reset since the count gates every read.
  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr_reg] <= grant_reg;
  end

  // ID FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PW+1)'(1);
        2'b01:   count_reg <= count_reg - (PW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Sticky flag for a result that shows up with no owner on record.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (bus.r_valid && fifo_empty) begin
      err_reg <= 1'b1;
    end
  end
endmodule

// File: doc/adder_stream_arbiter.md
Name: adder_stream_arbiter

Overview:
- Shares one N-beat summing stream engine (adder_AXI-style: N words in, one two-digit seven-segment result out) among K requester streams.
- Grants the engine to one requester for a whole N-beat group, using round-robin priority.
- Records the owner of each group in a small ID FIFO.
- Tags each returned result with that owner so results can be routed back.
- Sits between the requester sources and the shared adder instance.

Parameters:
- K, 4: number of requester streams; K >= 2.
- N, 8: beats per group; must equal the engine's N parameter.
- WIDTH, 8: data word width.
- RES_W, 14: result width; two packed 7-bit segment codes.
- ID_DEPTH, 4: depth of the outstanding-group ID FIFO; power of two.
- IDW, $clog2(K): width of the requester ID.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  K  per-requester valid.
- s_ready  out  K  per-requester ready.
- s_data  in  K x WIDTH  per-requester data.
- m_valid  out  1  valid to the engine input.
- m_ready  in  1  ready from the engine input.
- m_data  out  WIDTH  data to the engine.
- r_valid  in  1  engine result valid.
- r_ready  out  1  engine result ready.
- r_data  in  RES_W  engine result.
- o_valid  out  1  tagged result valid.
- o_ready  in  1  tagged result ready.
- o_data  out  RES_W  result passed through from r_data.
- o_id  out  IDW  requester that owns o_data.
- busy  out  1  high while in BURST.
- err  out  1  sticky flag: result arrived with no outstanding ID.

Behaviour:
- Reset (synchronous, rst high at posedge):
  - state = IDLE; grant = 0; rr_ptr = 0; beat counter = 0.
  - ID FIFO emptied; err = 0.
  - Outputs while in reset and after: s_ready = 0, m_valid = 0, r_ready = 0, o_valid = 0, busy = 0.
  - Reset mid-burst abandons the partial group. No ID is pushed for it.
- State machine: IDLE, BURST.
- IDLE:
  - Each cycle, if any s_valid is high and the FIFO count < ID_DEPTH:
    - grant = first requester with s_valid high, searching rr_ptr, rr_ptr+1, ... mod K.
    - Go to BURST next cycle; beat counter = 0.
  - Otherwise stay in IDLE.
  - m_valid = 0 and all s_ready = 0 in IDLE.
  - This gives a one-cycle bubble between groups.
- BURST:
  - m_valid = s_valid[grant]; m_data = s_data[grant].
  - s_ready[grant] = m_ready; all other s_ready = 0. Combinational, zero latency.
  - A beat transfers when m_valid && m_ready. Each transfer increments the counter.
  - Grant is locked for all N beats. If the granted requester drops valid mid-group, m_valid drops and the grant is held. No timeout.
  - On the transfer where counter = N-1:
    - push grant into the ID FIFO;
    - rr_ptr = (grant+1) mod K;
    - go to IDLE.
- Result path:
  - o_valid = r_valid && FIFO not empty.
  - r_ready = o_ready && FIFO not empty.
  - o_data = r_data; o_id = FIFO head.
  - Pop the FIFO on o_valid && o_ready.
- Error case: r_valid high while the FIFO is empty.
  - The result is not accepted (r_ready = 0).
  - err sets and stays set until rst.
- FIFO:
  - A push and a pop in the same cycle leave the count unchanged and both take effect.
  - Read and write pointers wrap mod ID_DEPTH.
  - When full, no new grant is issued. The in-progress burst is always pushable, because the grant check guarantees one free slot at grant time.
- Ordering:
  - The engine returns results in group order, so FIFO order equals result order.
  - No reordering is performed.

Test Plan:
- Single requester: only req 2 valid, m_ready = 1, data 1..8.
  - Expect: 8 beats forwarded contiguously after one IDLE cycle; s_ready[0,1,3] = 0 throughout.
  - Expect: ID FIFO gets 2; a result 0x1234 returns as o_data = 0x1234, o_id = 2.
- Round-robin: reqs 0, 1 and 3 continuously valid.
  - Expect: group grants in order 0, 1, 3, 0, 1, 3.
  - Expect: each group is exactly 8 beats; busy low for exactly one cycle between groups.
- Backpressure and stall: m_ready toggles 1-0-1-0 while the granted requester drops s_valid for 3 cycles mid-group.
  - Expect: grant held and exactly 8 transfers counted.
  - Expect: no beats from other requesters interleaved.
- FIFO full: o_ready = 0 and the engine holds results, with 5 groups requested.
  - Expect: 4 groups granted, then state stays IDLE and no s_ready asserts.
  - Expect: after one o handshake a 5th grant occurs; o_id sequence matches the grant order.
- Simultaneous push and pop: the last beat of group 2 coincides with the o handshake of group 1.
  - Expect: FIFO count unchanged; the next o_id is correct.
- Reset and error:
  - rst asserted at beat 4 of a group: all outputs 0 next cycle; rr_ptr = 0; FIFO empty; the next grant goes to the lowest valid requester.
  - r_valid with an empty FIFO: r_ready = 0, and err = 1 stays set until rst.
